// File: rtl/prog_loader.sv
// Boot-time program/data loader: parses a UART byte image (N_I, N_D, instruction
// words, data words, checksum) and streams the words into the two memories.
module prog_loader #(
  parameter int INST_MEM_WIDTH = 17,
  parameter int DATA_MEM_WIDTH = 19,
  parameter int WORD_BYTES     = 4,
  parameter int BIG_ENDIAN     = 0
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      start,
  input  logic [7:0]                rx_data,
  input  logic                      rx_valid,
  output logic                      inst_we,
  output logic [INST_MEM_WIDTH-1:0] inst_addr,
  output logic [8*WORD_BYTES-1:0]   inst_wdata,
  output logic                      data_we,
  output logic [DATA_MEM_WIDTH-1:0] data_addr,
  output logic [8*WORD_BYTES-1:0]   data_wdata,
  output logic                      busy,
  output logic                      done,
  output logic [1:0]                err,
  output logic [2:0]                state_dbg
);

  localparam int W   = 8 * WORD_BYTES;
  localparam int BCW = (WORD_BYTES > 4) ? $clog2(WORD_BYTES) : 2;
  localparam logic [BCW-1:0] LAST_WB = BCW'(WORD_BYTES - 1);
  localparam logic [BCW-1:0] LAST_HB = BCW'(3);
  localparam logic [63:0] INST_LIMIT = 64'd1 << INST_MEM_WIDTH;
  localparam logic [63:0] DATA_LIMIT = 64'd1 << DATA_MEM_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR_I, S_HDR_D, S_INST, S_DATA, S_CSUM, S_DONE, S_ERROR
  } state_e;

  state_e                    state_q;
  logic [BCW-1:0]            bcnt_q;
  logic [23:0]               hdr_q;
  logic [31:0]               n_i_q, n_d_q;
  logic [32:0]               wcnt_q;
  logic [W-1:0]              word_q;
  logic [7:0]                csum_q;
  logic [1:0]                err_q;
  logic                      inst_we_q, data_we_q;
  logic [INST_MEM_WIDTH-1:0] inst_addr_q;
  logic [DATA_MEM_WIDTH-1:0] data_addr_q;
  logic [W-1:0]              inst_wdata_q, data_wdata_q;

  logic [31:0]  hdr_d;
  logic [W-1:0] word_d;
  logic [32:0]  wcnt_d;
  logic         hdr_last, word_last, sect_end;

  always_comb begin
    hdr_d     = {rx_data, hdr_q};
    wcnt_d    = wcnt_q + 33'd1;
    hdr_last  = (bcnt_q == LAST_HB);
    word_last = (bcnt_q == LAST_WB);
    // Shifting keeps the assembly legal for any WORD_BYTES, including 1.
    if (BIG_ENDIAN != 0) word_d = (word_q << 8) | W'(rx_data);
    else                 word_d = (word_q >> 8) | (W'(rx_data) << (W - 8));
    sect_end  = (wcnt_d == {1'b0, (state_q == S_INST) ? n_i_q : n_d_q});
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= S_IDLE;
      bcnt_q       <= '0;
      hdr_q        <= '0;
      n_i_q        <= '0;
      n_d_q        <= '0;
      wcnt_q       <= '0;
      word_q       <= '0;
      csum_q       <= '0;
      err_q        <= '0;
      inst_we_q    <= 1'b0;
      data_we_q    <= 1'b0;
      inst_addr_q  <= '0;
      data_addr_q  <= '0;
      inst_wdata_q <= '0;
      data_wdata_q <= '0;
    end else begin
      inst_we_q <= 1'b0;
      data_we_q <= 1'b0;
      if (start) begin
        state_q     <= S_HDR_I;
        bcnt_q      <= '0;
        wcnt_q      <= '0;
        csum_q      <= '0;
        err_q       <= '0;
        inst_addr_q <= '0;
        data_addr_q <= '0;
      end else if (rx_valid) begin
        case (state_q)
          S_HDR_I: begin
            hdr_q  <= hdr_d[31:8];
            bcnt_q <= bcnt_q + 1'b1;
            if (hdr_last) begin
              bcnt_q <= '0;
              n_i_q  <= hdr_d;
              if ({32'd0, hdr_d} > INST_LIMIT) begin
                state_q <= S_ERROR;
                err_q   <= 2'b01;
              end else begin
                state_q <= S_HDR_D;
              end
            end
          end
          S_HDR_D: begin
            hdr_q  <= hdr_d[31:8];
            bcnt_q <= bcnt_q + 1'b1;
            if (hdr_last) begin
              bcnt_q <= '0;
              n_d_q  <= hdr_d;
              if ({32'd0, hdr_d} > DATA_LIMIT) begin
                state_q <= S_ERROR;
                err_q   <= 2'b01;
              end else if (n_i_q != 32'd0) state_q <= S_INST;
              else if (hdr_d != 32'd0)     state_q <= S_DATA;
              else                         state_q <= S_CSUM;
            end
          end
          S_INST, S_DATA: begin
            word_q <= word_d;
            csum_q <= csum_q + rx_data;
            bcnt_q <= bcnt_q + 1'b1;
            if (word_last) begin
              bcnt_q <= '0;
              // The address register holds the index of the word being written,
              // so it reaches 2**WIDTH-1 at most and never wraps.
              if (state_q == S_INST) begin
                inst_we_q    <= 1'b1;
                inst_addr_q  <= wcnt_q[INST_MEM_WIDTH-1:0];
                inst_wdata_q <= word_d;
              end else begin
                data_we_q    <= 1'b1;
                data_addr_q  <= wcnt_q[DATA_MEM_WIDTH-1:0];
                data_wdata_q <= word_d;
              end
              if (sect_end) begin
                wcnt_q <= '0;
                if (state_q == S_INST && n_d_q != 32'd0) state_q <= S_DATA;
                else                                     state_q <= S_CSUM;
              end else begin
                wcnt_q <= wcnt_d;
              end
            end
          end
          S_CSUM: begin
            if (rx_data == csum_q) begin
              state_q <= S_DONE;
            end else begin
              state_q <= S_ERROR;
              err_q   <= 2'b10;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign inst_we    = inst_we_q;
  assign inst_addr  = inst_addr_q;
  assign inst_wdata = inst_wdata_q;
  assign data_we    = data_we_q;
  assign data_addr  = data_addr_q;
  assign data_wdata = data_wdata_q;
  assign busy       = state_q inside {S_HDR_I, S_HDR_D, S_INST, S_DATA, S_CSUM};
  assign done       = (state_q == S_DONE);
  assign err        = err_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: a default instance (A) and a small big-endian instance (B),
// each fed directed and random images and checked against a stream-level model.
module tb_prog_loader;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [7:0]  rx_data;
  logic        start_a, rx_valid_a, start_b, rx_valid_b;

  logic        a_inst_we, a_data_we, a_busy, a_done;
  logic [16:0] a_inst_addr;
  logic [18:0] a_data_addr;
  logic [31:0] a_inst_wdata, a_data_wdata;
  logic [1:0]  a_err;
  logic [2:0]  a_state;

  logic        b_inst_we, b_data_we, b_busy, b_done;
  logic [3:0]  b_inst_addr, b_data_addr;
  logic [31:0] b_inst_wdata, b_data_wdata;
  logic [1:0]  b_err;
  logic [2:0]  b_state;

  always #5 CLK = ~CLK;

  prog_loader u_a (
    .CLK(CLK), .RST_N(RST_N), .start(start_a), .rx_data(rx_data), .rx_valid(rx_valid_a),
    .inst_we(a_inst_we), .inst_addr(a_inst_addr), .inst_wdata(a_inst_wdata),
    .data_we(a_data_we), .data_addr(a_data_addr), .data_wdata(a_data_wdata),
    .busy(a_busy), .done(a_done), .err(a_err), .state_dbg(a_state)
  );

  prog_loader #(.INST_MEM_WIDTH(4), .DATA_MEM_WIDTH(4), .WORD_BYTES(4), .BIG_ENDIAN(1)) u_b (
    .CLK(CLK), .RST_N(RST_N), .start(start_b), .rx_data(rx_data), .rx_valid(rx_valid_b),
    .inst_we(b_inst_we), .inst_addr(b_inst_addr), .inst_wdata(b_inst_wdata),
    .data_we(b_data_we), .data_addr(b_data_addr), .data_wdata(b_data_wdata),
    .busy(b_busy), .done(b_done), .err(b_err), .state_dbg(b_state)
  );

  localparam logic [63:0] ST_IDLE  = 64'd0;
  localparam logic [63:0] ST_DONE  = 64'd6;
  localparam logic [63:0] ST_ERROR = 64'd7;

  typedef struct {
    bit          is_data;
    longint      addr;
    logic [31:0] data;
  } wr_t;

  wr_t         got_a[$], got_b[$], exp_w[$];
  logic [7:0]  stim[$];
  logic [1:0]  exp_err;
  bit          exp_done;
  int          overlap_a = 0, overlap_b = 0;
  int          checks = 0, errors = 0;

  always @(negedge CLK) begin
    if (a_inst_we) got_a.push_back('{1'b0, longint'(a_inst_addr), a_inst_wdata});
    if (a_data_we) got_a.push_back('{1'b1, longint'(a_data_addr), a_data_wdata});
    if (b_inst_we) got_b.push_back('{1'b0, longint'(b_inst_addr), b_inst_wdata});
    if (b_data_we) got_b.push_back('{1'b1, longint'(b_data_addr), b_data_wdata});
    if (a_inst_we && a_data_we) overlap_a++;
    if (b_inst_we && b_data_we) overlap_b++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, required finish within 50000 cycles");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  // Image of random words with a correct or deliberately wrong checksum.
  task automatic gen(input int unsigned ni, input int unsigned nd, input bit bad);
    logic [7:0] sum, b;
    sum = 8'h00;
    stim.delete();
    for (int i = 0; i < 4; i++) stim.push_back(8'(ni >> (8 * i)));
    for (int i = 0; i < 4; i++) stim.push_back(8'(nd >> (8 * i)));
    for (int unsigned i = 0; i < 4 * (ni + nd); i++) begin
      b = 8'($urandom);
      stim.push_back(b);
      sum = sum + b;
    end
    stim.push_back(bad ? sum + 8'($urandom_range(1, 255)) : sum);
  endtask

  // Parses stim as the loader should: header limits, word packing, checksum.
  function automatic void model(input int iw, input int dw, input bit be);
    longint     ni, nd;
    int         p;
    logic [7:0] sum;
    logic [31:0] word;
    exp_w.delete();
    exp_err  = 2'b00;
    exp_done = 1'b0;
    ni = longint'({stim[3], stim[2], stim[1], stim[0]});
    nd = longint'({stim[7], stim[6], stim[5], stim[4]});
    if (ni > (longint'(1) << iw) || nd > (longint'(1) << dw)) begin
      exp_err = 2'b01;
      return;
    end
    p   = 8;
    sum = 8'h00;
    for (longint k = 0; k < ni + nd; k++) begin
      word = '0;
      for (int b = 0; b < 4; b++) begin
        if (be) word[8*(3-b) +: 8] = stim[p];
        else    word[8*b +: 8]     = stim[p];
        sum = sum + stim[p];
        p++;
      end
      exp_w.push_back('{k >= ni, (k >= ni) ? k - ni : k, word});
    end
    if (stim[p] == sum) exp_done = 1'b1;
    else                exp_err  = 2'b10;
  endfunction

  task automatic arm(input bit to_b);
    if (to_b) start_b = 1'b1; else start_a = 1'b1;
    cyc();
    start_a = 1'b0;
    start_b = 1'b0;
    got_a.delete();
    got_b.delete();
  endtask

  task automatic send(input bit to_b, input bit gaps, input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      rx_data = stim[i];
      if (to_b) rx_valid_b = 1'b1; else rx_valid_a = 1'b1;
      cyc();
      rx_valid_a = 1'b0;
      rx_valid_b = 1'b0;
      if (gaps) repeat ($urandom_range(0, 2)) cyc();
    end
  endtask

  task automatic check_run(input string tag, input bit to_b);
    wr_t g[$];
    if (to_b) g = got_b; else g = got_a;
    chk({tag, " writes"}, 64'(g.size()), 64'(exp_w.size()));
    for (int i = 0; i < exp_w.size() && i < g.size(); i++) begin
      chk($sformatf("%s w%0d kind", tag, i), 64'(g[i].is_data), 64'(exp_w[i].is_data));
      chk($sformatf("%s w%0d addr", tag, i), 64'(g[i].addr), 64'(exp_w[i].addr));
      chk($sformatf("%s w%0d data", tag, i), 64'(g[i].data), 64'(exp_w[i].data));
    end
    if (to_b) begin
      chk({tag, " done"}, 64'(b_done), 64'(exp_done));
      chk({tag, " err"}, 64'(b_err), 64'(exp_err));
      chk({tag, " state"}, 64'(b_state), exp_done ? ST_DONE : ST_ERROR);
      chk({tag, " busy"}, 64'(b_busy), 64'd0);
      chk({tag, " overlap"}, 64'(overlap_b), 64'd0);
    end else begin
      chk({tag, " done"}, 64'(a_done), 64'(exp_done));
      chk({tag, " err"}, 64'(a_err), 64'(exp_err));
      chk({tag, " state"}, 64'(a_state), exp_done ? ST_DONE : ST_ERROR);
      chk({tag, " busy"}, 64'(a_busy), 64'd0);
      chk({tag, " overlap"}, 64'(overlap_a), 64'd0);
    end
  endtask

  task automatic run(input string tag, input bit to_b, input bit gaps);
    if (to_b) model(4, 4, 1'b1); else model(17, 19, 1'b0);
    arm(to_b);
    send(to_b, gaps, 0, stim.size());
    cyc();
    check_run(tag, to_b);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " A ctl"}, 64'({a_inst_we, a_inst_addr, a_data_we, a_data_addr,
                              a_busy, a_done, a_err, a_state}), 64'd0);
    chk({tag, " A wdata"}, {a_inst_wdata, a_data_wdata}, 64'd0);
    chk({tag, " B ctl"}, 64'({b_inst_we, b_inst_addr, b_data_we, b_data_addr,
                              b_busy, b_done, b_err, b_state}), 64'd0);
  endtask

  initial begin
    RST_N = 1'b1;
    start_a = 1'b0; start_b = 1'b0;
    rx_valid_a = 1'b0; rx_valid_b = 1'b0;
    rx_data = 8'h00;
    #3 RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check_reset_outputs("reset");
    RST_N = 1'b1;
    cyc();

    stim = {8'h02, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
            8'h05, 8'h00, 8'h01, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00,
            8'h00, 8'h00, 8'h80, 8'h3F, 8'hE5};
    run("spec_ok", 1'b0, 1'b0);
    if (got_a.size() == 3) begin
      chk("spec inst0", 64'(got_a[0].data), 64'h20010005);
      chk("spec data0", 64'(got_a[2].data), 64'h3F800000);
    end

    stim[20] = 8'hE4;
    run("spec_bad_csum", 1'b0, 1'b0);

    // N_I one past capacity: error must appear right after header byte 4.
    stim = {8'd17, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    model(4, 4, 1'b1);
    arm(1'b1);
    send(1'b1, 1'b0, 0, 4);
    chk("size err timing", 64'(b_err), 64'd1);
    chk("size err state", 64'(b_state), ST_ERROR);
    send(1'b1, 1'b0, 4, 8);
    cyc();
    check_run("size_err", 1'b1);

    gen(16, 0, 1'b0);
    run("full_fill", 1'b1, 1'b0);

    stim = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run("empty", 1'b0, 1'b0);

    // Restart mid-stream, with a byte arriving in the same cycle as start.
    stim = {8'h02, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00};
    arm(1'b0);
    send(1'b0, 1'b0, 0, stim.size());
    start_a = 1'b1; rx_valid_a = 1'b1; rx_data = 8'hAA;
    cyc();
    start_a = 1'b0; rx_valid_a = 1'b0;
    got_a.delete();
    gen(2, 1, 1'b0);
    model(17, 19, 1'b0);
    send(1'b0, 1'b1, 0, stim.size());
    cyc();
    check_run("restart", 1'b0);

    stim = {8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
            8'h20, 8'h01, 8'h00, 8'h05, 8'h26};
    run("big_endian", 1'b1, 1'b0);
    if (got_b.size() == 1) chk("be word", 64'(got_b[0].data), 64'h20010005);

    for (int i = 0; i < 10; i++) begin
      bit          to_b;
      int unsigned ni, nd;
      to_b = i[0];
      ni = $urandom_range(0, 4);
      nd = to_b ? $urandom_range(0, 18) : $urandom_range(0, 4);
      if (to_b && $urandom_range(0, 3) == 0) ni = 17;
      gen(ni, nd, $urandom_range(0, 3) == 0);
      run($sformatf("rand%0d", i), to_b, 1'b1);
    end

    // Reset asserted while a write strobe is high in the middle of INST.
    gen(3, 0, 1'b0);
    model(17, 19, 1'b0);
    arm(1'b0);
    send(1'b0, 1'b0, 0, 12);
    chk("mid we", 64'(a_inst_we), 64'd1);
    chk("mid addr", 64'(a_inst_addr), 64'd0);
    chk("mid data", 64'(a_inst_wdata), 64'(exp_w[0].data));
    chk("mid busy", 64'(a_busy), 64'd1);
    RST_N = 1'b0;
    #1;
    check_reset_outputs("async reset");
    @(posedge CLK);
    #1 RST_N = 1'b1;
    cyc();
    got_a.delete();
    send(1'b0, 1'b0, 12, stim.size());
    cyc();
    chk("idle ignores rx", 64'(a_state), ST_IDLE);
    chk("idle no writes", 64'(got_a.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
